// File: rtl/alu_mode_sequencer.sv
// Front-end controller: synchronizes and debounces the push switches, turns accepted
// presses into an operation select with an operand snapshot, and drives the digit scan.
module alu_mode_sequencer #(
   parameter int DB_COUNT = 4,
   parameter int DB_W     = 16,
   parameter int SCAN_DIV = 3,
   parameter int SCAN_W   = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] PUSHSW_input,
   input  logic [9:0] DIP_input,
   output logic [2:0] mode,
   output logic [9:0] operand_latched,
   output logic       load_pulse,
   output logic [2:0] digit_idx,
   output logic [5:0] digit_sel
);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_COUNT - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } state_t;

   logic [5:0]      r_pushMeta;
   logic [5:0]      r_pushSync;
   logic [9:0]      r_dipMeta;
   logic [9:0]      r_dipSync;
   logic [DB_W-1:0] r_dbCount [6];
   logic [5:0]      r_stable;
   logic [5:0]      r_stablePrev;
   state_t          r_state;
   logic [2:0]      r_mode;
   logic [9:0]      r_operand;
   logic            r_loadPulse;
   logic [SCAN_W-1:0] r_prescale;
   logic [2:0]      r_digitIdx;
   logic [5:0]      r_digitSel;

   logic [5:0]      w_press;
   logic            w_anyPress;
   logic [2:0]      w_pressIdx;
   logic [2:0]      w_nextMode;
   logic [2:0]      w_nextDigit;

   // Both raw inputs are asynchronous to clk, so each gets a two-flop synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pushMeta <= '0;
         r_pushSync <= '0;
         r_dipMeta  <= '0;
         r_dipSync  <= '0;
      end else begin
         r_pushMeta <= PUSHSW_input;
         r_pushSync <= r_pushMeta;
         r_dipMeta  <= DIP_input;
         r_dipSync  <= r_dipMeta;
      end
   end

   // A switch level is accepted only after DB_COUNT consecutive samples that differ
   // from the current stable level; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) begin
            r_dbCount[i] <= '0;
         end
         r_stable     <= '0;
         r_stablePrev <= '0;
      end else begin
         r_stablePrev <= r_stable;
         for (int i = 0; i < 6; i++) begin
            if (r_pushSync[i] == r_stable[i]) begin
               r_dbCount[i] <= '0;
            end else if (r_dbCount[i] == DB_LAST) begin
               r_stable[i]  <= r_pushSync[i];
               r_dbCount[i] <= '0;
            end else begin
               r_dbCount[i] <= r_dbCount[i] + DB_W'(1);
            end
         end
      end
   end

   assign w_press    = r_stable & ~r_stablePrev;
   assign w_anyPress = |w_press;

   // Scanning from the top down leaves the lowest pressed index as the winner.
   always_comb begin
      w_pressIdx = '0;
      for (int i = 5; i >= 0; i--) begin
         if (w_press[i]) begin
            w_pressIdx = 3'(i);
         end
      end
   end

   assign w_nextMode = w_pressIdx + 3'd1;

   // One press per hold: after accepting, wait until every switch is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mode      <= '0;
         r_operand   <= '0;
         r_loadPulse <= 1'b0;
      end else begin
         r_loadPulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_anyPress) begin
                  r_loadPulse <= 1'b1;
                  r_operand   <= r_dipSync;
                  r_mode      <= (r_mode == w_nextMode) ? 3'd0 : w_nextMode;
                  r_state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (r_stable == 6'b000000) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_nextDigit = (r_digitIdx == 3'd5) ? 3'd0 : r_digitIdx + 3'd1;

   // The digit scan free-runs regardless of the press FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale <= '0;
         r_digitIdx <= '0;
         r_digitSel <= 6'b111110;
      end else if (r_prescale == SCAN_LAST) begin
         r_prescale <= '0;
         r_digitIdx <= w_nextDigit;
         r_digitSel <= ~(6'b000001 << w_nextDigit);
      end else begin
         r_prescale <= r_prescale + SCAN_W'(1);
      end
   end

   assign mode            = r_mode;
   assign operand_latched = r_operand;
   assign load_pulse      = r_loadPulse;
   assign digit_idx       = r_digitIdx;
   assign digit_sel       = r_digitSel;

endmodule

// File: tb/tb_alu_mode_sequencer.sv
// Directed bench for alu_mode_sequencer: reset, scan, press latency, toggling,
// simultaneous presses, glitch rejection and reset while a switch is held.
module tb_alu_mode_sequencer;

   logic       clk;
   logic       rst;
   logic [5:0] PUSHSW_input;
   logic [9:0] DIP_input;
   logic [2:0] mode;
   logic [9:0] operand_latched;
   logic       load_pulse;
   logic [2:0] digit_idx;
   logic [5:0] digit_sel;

   int vectorCount = 0;
   int missCount   = 0;

   alu_mode_sequencer #(
      .DB_COUNT(4),
      .DB_W(16),
      .SCAN_DIV(3),
      .SCAN_W(17)
   ) dut (
      .clk(clk),
      .rst(rst),
      .PUSHSW_input(PUSHSW_input),
      .DIP_input(DIP_input),
      .mode(mode),
      .operand_latched(operand_latched),
      .load_pulse(load_pulse),
      .digit_idx(digit_idx),
      .digit_sel(digit_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic runCount(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         tick();
         if (load_pulse === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      PUSHSW_input = '0;
      DIP_input = '0;
      tick();
      tick();
      vectorCount++;
      if (mode !== 3'd0) begin
         missCount++;
         $display("[TB] FAIL reset_mode: got %0d want 0", mode);
      end
      vectorCount++;
      if (operand_latched !== 10'h000) begin
         missCount++;
         $display("[TB] FAIL reset_operand: got %h want 000", operand_latched);
      end
      vectorCount++;
      if (load_pulse !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_load: got %b want 0", load_pulse);
      end
      vectorCount++;
      if (digit_sel !== 6'b111110 || digit_idx !== 3'd0) begin
         missCount++;
         $display("[TB] FAIL reset_scan: got idx=%0d sel=%b want idx=0 sel=111110", digit_idx, digit_sel);
      end
      rst = 1'b0;
      repeat (3) tick();
      vectorCount++;
      if (digit_sel !== 6'b111101 || digit_idx !== 3'd1) begin
         missCount++;
         $display("[TB] FAIL scan_step: got idx=%0d sel=%b want idx=1 sel=111101", digit_idx, digit_sel);
      end
      repeat (12) tick();
      vectorCount++;
      if (digit_sel !== 6'b011111 || digit_idx !== 3'd5) begin
         missCount++;
         $display("[TB] FAIL scan_last: got idx=%0d sel=%b want idx=5 sel=011111", digit_idx, digit_sel);
      end
      repeat (3) tick();
      vectorCount++;
      if (digit_sel !== 6'b111110 || digit_idx !== 3'd0) begin
         missCount++;
         $display("[TB] FAIL scan_wrap: got idx=%0d sel=%b want idx=0 sel=111110", digit_idx, digit_sel);
      end
   endtask

   task automatic test_press_latency();
      int pulses;
      DIP_input = 10'h2A5;
      PUSHSW_input = 6'b000100;
      runCount(6, pulses);
      vectorCount++;
      if (pulses !== 0) begin
         missCount++;
         $display("[TB] FAIL early_pulse: got %0d pulses want 0 before edge 7", pulses);
      end
      tick();
      vectorCount++;
      if (load_pulse !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL latency_pulse: got %b want 1 at edge 7", load_pulse);
      end
      vectorCount++;
      if (mode !== 3'd3) begin
         missCount++;
         $display("[TB] FAIL press_mode: got %0d want 3", mode);
      end
      vectorCount++;
      if (operand_latched !== 10'h2A5) begin
         missCount++;
         $display("[TB] FAIL press_operand: got %h want 2a5", operand_latched);
      end
      runCount(13, pulses);
      vectorCount++;
      if (pulses !== 0) begin
         missCount++;
         $display("[TB] FAIL held_repeat: got %0d extra pulses want 0", pulses);
      end
      DIP_input = 10'h011;
      repeat (5) tick();
      vectorCount++;
      if (operand_latched !== 10'h2A5) begin
         missCount++;
         $display("[TB] FAIL operand_hold: got %h want 2a5", operand_latched);
      end
      PUSHSW_input = '0;
      runCount(10, pulses);
      vectorCount++;
      if (pulses !== 0 || mode !== 3'd3) begin
         missCount++;
         $display("[TB] FAIL release: got pulses=%0d mode=%0d want 0 and 3", pulses, mode);
      end
   endtask

   task automatic test_toggle();
      int pulses;
      PUSHSW_input = 6'b000100;
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 1 || mode !== 3'd0) begin
         missCount++;
         $display("[TB] FAIL toggle_off: got pulses=%0d mode=%0d want 1 and 0", pulses, mode);
      end
      PUSHSW_input = '0;
      repeat (10) tick();
      PUSHSW_input = 6'b100000;
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 1 || mode !== 3'd6) begin
         missCount++;
         $display("[TB] FAIL switch5: got pulses=%0d mode=%0d want 1 and 6", pulses, mode);
      end
      PUSHSW_input = '0;
      repeat (10) tick();
   endtask

   task automatic test_simultaneous();
      int pulses;
      PUSHSW_input = 6'b001010;
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 1 || mode !== 3'd2) begin
         missCount++;
         $display("[TB] FAIL simul_lowest: got pulses=%0d mode=%0d want 1 and 2", pulses, mode);
      end
      PUSHSW_input = 6'b001000;
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 0 || mode !== 3'd2) begin
         missCount++;
         $display("[TB] FAIL simul_discard: got pulses=%0d mode=%0d want 0 and 2", pulses, mode);
      end
      PUSHSW_input = '0;
      repeat (10) tick();
      PUSHSW_input = 6'b001000;
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 1 || mode !== 3'd4) begin
         missCount++;
         $display("[TB] FAIL simul_repress: got pulses=%0d mode=%0d want 1 and 4", pulses, mode);
      end
      PUSHSW_input = '0;
      repeat (10) tick();
   endtask

   task automatic test_glitch();
      int pulses;
      int total;
      logic [4:0] bounce;
      PUSHSW_input = 6'b000001;
      repeat (3) tick();
      PUSHSW_input = '0;
      runCount(15, pulses);
      vectorCount++;
      if (pulses !== 0 || mode !== 3'd4) begin
         missCount++;
         $display("[TB] FAIL glitch: got pulses=%0d mode=%0d want 0 and 4", pulses, mode);
      end
      bounce = 5'b01101;
      total = 0;
      for (int i = 4; i >= 0; i--) begin
         PUSHSW_input = {5'b00000, bounce[i]};
         tick();
         if (load_pulse === 1'b1) total++;
      end
      PUSHSW_input = 6'b000001;
      runCount(20, pulses);
      total += pulses;
      vectorCount++;
      if (total !== 1 || mode !== 3'd1) begin
         missCount++;
         $display("[TB] FAIL bounce: got pulses=%0d mode=%0d want 1 and 1", total, mode);
      end
      PUSHSW_input = '0;
      repeat (10) tick();
   endtask

   task automatic test_reset_hold();
      int pulses;
      PUSHSW_input = 6'b000010;
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 1 || mode !== 3'd2) begin
         missCount++;
         $display("[TB] FAIL hold_setup: got pulses=%0d mode=%0d want 1 and 2", pulses, mode);
      end
      rst = 1'b1;
      tick();
      vectorCount++;
      if (mode !== 3'd0 || operand_latched !== 10'h000 || load_pulse !== 1'b0 ||
          digit_idx !== 3'd0 || digit_sel !== 6'b111110) begin
         missCount++;
         $display("[TB] FAIL hold_reset: got mode=%0d op=%h load=%b idx=%0d sel=%b want 0 000 0 0 111110",
                  mode, operand_latched, load_pulse, digit_idx, digit_sel);
      end
      rst = 1'b0;
      runCount(6, pulses);
      vectorCount++;
      if (pulses !== 0) begin
         missCount++;
         $display("[TB] FAIL rehold_early: got %0d pulses want 0", pulses);
      end
      tick();
      vectorCount++;
      if (load_pulse !== 1'b1 || mode !== 3'd2 || operand_latched !== 10'h011) begin
         missCount++;
         $display("[TB] FAIL rehold_press: got load=%b mode=%0d op=%h want 1 2 011",
                  load_pulse, mode, operand_latched);
      end
      runCount(20, pulses);
      vectorCount++;
      if (pulses !== 0 || mode !== 3'd2) begin
         missCount++;
         $display("[TB] FAIL rehold_repeat: got pulses=%0d mode=%0d want 0 and 2", pulses, mode);
      end
      PUSHSW_input = '0;
      repeat (10) tick();
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_toggle();
      test_simultaneous();
      test_glitch();
      test_reset_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
